mul_div_unit: RTL

//  Iterative 16-bit multiply/divide unit in the execute stage, downstream of the control

---
 rtl/mul_div_unit_pkg.sv | 21 ++
 rtl/md_datapath.sv | 104 ++++++++++
 rtl/mul_div_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit and the control decoder.
package mul_div_unit_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 5;

  typedef enum logic [1:0] {
    MD_NOP  = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_MULU = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/md_datapath.sv
// Shift-add multiplier / restoring divider on magnitudes, with sign and
// divide-by-zero correction applied combinationally for capture in FIX.
module md_datapath
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_resetN,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [1:0]       i_multiDiv,
  input  logic [WIDTH-1:0] i_opA,
  input  logic [WIDTH-1:0] i_opB,
  output logic [WIDTH-1:0] o_res_hi,
  output logic [WIDTH-1:0] o_res_lo,
  output logic             o_div_by_zero
);

  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_raw_a;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_is_div;
  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic               w_ge;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_prod;

  assign w_is_div = (i_multiDiv == MD_DIV);
  assign w_signed = (i_multiDiv != MD_MULU);
  assign w_sa     = w_signed & i_opA[WIDTH-1];
  assign w_sb     = w_signed & i_opB[WIDTH-1];
  // Magnitude of the most negative value wraps to itself, which is correct unsigned.
  assign w_mag_a  = w_sa ? (~i_opA + 1'b1) : i_opA;
  assign w_mag_b  = w_sb ? (~i_opB + 1'b1) : i_opB;

  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_opnd});
  assign w_rem   = w_ge ? WIDTH'(w_shift - {1'b0, r_opnd}) : w_shift[WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
      r_opnd   <= '0;
      r_raw_a  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (i_load) begin
      r_is_div <= w_is_div;
      r_neg_q  <= w_sa ^ w_sb;
      r_neg_r  <= w_sa;
      r_dbz    <= w_is_div && (i_opB == '0);
      r_raw_a  <= i_opA;
      r_hi     <= '0;
      r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
      r_lo     <= w_is_div ? w_mag_a : w_mag_b;
    end else if (i_step) begin
      if (r_is_div) begin
        r_hi <= w_rem;
        r_lo <= {r_lo[WIDTH-2:0], w_ge};
      end else begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  assign w_prod = {r_hi, r_lo};

  always_comb begin
    o_res_hi = '0;
    o_res_lo = '0;
    if (r_is_div) begin
      if (r_dbz) begin
        o_res_hi = r_raw_a;
        o_res_lo = '1;
      end else begin
        o_res_lo = r_neg_q ? (~r_lo + 1'b1) : r_lo;
        o_res_hi = r_neg_r ? (~r_hi + 1'b1) : r_hi;
      end
    end else begin
      {o_res_hi, o_res_lo} = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    end
  end

  assign o_div_by_zero = r_dbz;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 16-bit multiply/divide unit; stalls the pipeline for the 18 cycles
// between accepting a request and presenting the 32-bit result.
//
//   state  | meaning
//   S_IDLE | waiting for a request
//   S_RUN  | one multiply/divide step per edge, 16 edges
//   S_FIX  | sign correction, result captured on leaving
//   S_DONE | result valid for one cycle, may accept the next request
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_resetN,
  input  logic             i_start,
  input  logic [1:0]       i_multiDiv,
  input  logic [WIDTH-1:0] i_opA,
  input  logic [WIDTH-1:0] i_opB,
  output logic [WIDTH-1:0] o_resultHi,
  output logic [WIDTH-1:0] o_resultLo,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_divByZero
);

  md_state_e        r_state;
  md_state_e        w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_busy;
  logic             r_dbz;

  logic             w_accept;
  logic             w_go;
  logic             w_tc;
  logic             w_step;
  logic             w_fix;
  logic             w_busy_nxt;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic             w_dbz;

  assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_go     = w_accept && (i_multiDiv != MD_NOP);
  assign w_tc     = (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (!i_resetN) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_go) w_next = S_RUN;
      S_RUN:   if (w_tc) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = w_go ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_step     = (r_state == S_RUN);
    w_fix      = (r_state == S_FIX);
    w_busy_nxt = (w_next == S_RUN) || (w_next == S_FIX);
  end

  // Down-counter: loaded on accept, terminal count ends the 16th RUN edge.
  always_ff @(posedge i_clk) begin
    if (!i_resetN)   r_cnt <= '0;
    else if (w_go)   r_cnt <= CNT_W'(WIDTH - 1);
    else if (w_step && !w_tc) r_cnt <= r_cnt - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= w_fix;
      r_busy <= w_busy_nxt;
      if (w_fix) begin
        r_hi  <= w_res_hi;
        r_lo  <= w_res_lo;
        r_dbz <= w_dbz;
      end else if (w_go) begin
        r_dbz <= 1'b0;
      end
    end
  end

  md_datapath #(.WIDTH(WIDTH)) u_datapath (
    .i_clk         (i_clk),
    .i_resetN      (i_resetN),
    .i_load        (w_go),
    .i_step        (w_step),
    .i_multiDiv    (i_multiDiv),
    .i_opA         (i_opA),
    .i_opB         (i_opB),
    .o_res_hi      (w_res_hi),
    .o_res_lo      (w_res_lo),
    .o_div_by_zero (w_dbz)
  );

  assign o_resultHi  = r_hi;
  assign o_resultLo  = r_lo;
  assign o_done      = r_done;
  assign o_busy      = r_busy;
  assign o_divByZero = r_dbz;
  assign o_stall     = w_go | r_busy;

endmodule
